// File: rtl/stk_ram_rsp_if.sv
// Stack spill/fill RAM port: write bursts and read bursts from the stack controller,
// with read data returned on rd_ack.
interface StkRamIf #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 98
);
  logic          wr_vld;
  logic [AW-1:0] wr_adr;
  logic [DW-1:0] wr_dat;
  logic          wr_rdy;
  logic          rd_vld;
  logic [AW-1:0] rd_adr;
  logic          rd_rdy;
  logic          rd_ack;
  logic [DW-1:0] rd_dat;

  modport Master (
    output wr_vld, wr_adr, wr_dat, rd_vld, rd_adr,
    input  wr_rdy, rd_rdy, rd_ack, rd_dat
  );

  modport Slave (
    input  wr_vld, wr_adr, wr_dat, rd_vld, rd_adr,
    output wr_rdy, rd_rdy, rd_ack, rd_dat
  );
endinterface

// File: rtl/stk_ram_rsp.sv
// Responder for the stack spill/fill RAM: zero sweep after reset, write/read service
// with backpressure, fixed-latency read return and a sticky out-of-range flag.
module stk_ram_rsp #(
  parameter int unsigned DW        = 98,
  parameter int unsigned RAM_DEPTH = 24,
  parameter int unsigned AW        = $clog2(RAM_DEPTH + 8),
  parameter int unsigned RD_LAT    = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   ext_stall,
  StkRamIf.Slave stk_ram_if,
  output logic   init_done,
  output logic   err_oor
);

  localparam int unsigned   CW       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A  = AW'(RAM_DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(RAM_DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic [DW-1:0] r_mem [RAM_DEPTH];

  logic              w_run;
  logic              w_port_ok;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_wr_in;
  logic              w_rd_in;
  logic [DW-1:0]     w_rd_dat;
  logic              r_err;
  logic [RD_LAT-1:0] r_pvld;
  logic [DW-1:0]     r_pdat [RD_LAT];

  // State register and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: sweep one word per cycle, then stay in RUN until reset
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_run     = (r_state == ST_RUN);
  assign w_port_ok = w_run && !ext_stall && !clear;

  assign stk_ram_if.wr_rdy = w_port_ok;
  assign stk_ram_if.rd_rdy = w_port_ok && !stk_ram_if.wr_vld;

  assign w_wr_acc = stk_ram_if.wr_vld && w_port_ok;
  assign w_rd_acc = stk_ram_if.rd_vld && w_port_ok && !stk_ram_if.wr_vld;
  assign w_wr_in  = (stk_ram_if.wr_adr < DEPTH_A);
  assign w_rd_in  = (stk_ram_if.rd_adr < DEPTH_A);

  // Out-of-range reads return zero rather than aliasing onto a real word
  assign w_rd_dat = w_rd_in ? r_mem[CW'(stk_ram_if.rd_adr)] : '0;

  // Storage: zero sweep during INIT, accepted in-range writes during RUN
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_acc && w_wr_in) begin
      r_mem[CW'(stk_ram_if.wr_adr)] <= stk_ram_if.wr_dat;
    end
  end

  // Sticky range error; clear takes priority over a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (clear) begin
      r_err <= 1'b0;
    end else if ((w_wr_acc && !w_wr_in) || (w_rd_acc && !w_rd_in)) begin
      r_err <= 1'b1;
    end
  end

  // Read return pipeline; data stages only load on a valid so rd_dat holds between acks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pvld <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        r_pdat[i] <= '0;
      end
    end else begin
      r_pvld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_pdat[0] <= w_rd_dat;
      end
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_pvld[i] <= r_pvld[i-1] && !clear;
        if (r_pvld[i-1] && !clear) begin
          r_pdat[i] <= r_pdat[i-1];
        end
      end
    end
  end

  assign stk_ram_if.rd_ack = r_pvld[RD_LAT-1];
  assign stk_ram_if.rd_dat = r_pdat[RD_LAT-1];
  assign init_done         = w_run;
  assign err_oor           = r_err;

endmodule

// File: doc/stk_ram_rsp.md
# stk_ram_rsp

Responder end of the stack spill/fill RAM interface. It serves the write bursts (register-stack spill) and read bursts (fill) issued by the stack controller over `StkRamIf`, and owns the backing storage for the stack words beyond the register cache. It zero-initialises the array after reset, applies backpressure through `wr_rdy`/`rd_rdy`, returns read data with a fixed latency on `rd_ack`, and flags out-of-range accesses.

## Interface
- `DW`, 98, stack word width.
- `RAM_DEPTH`, 24, number of RAM words (total stack depth minus the 8-entry register cache).
- `AW`, `$clog2(RAM_DEPTH+8)`, address width; matches the controller's stack-pointer width.
- `RD_LAT`, 1, read latency in cycles from accept to `rd_ack`; legal values are 1 or 2.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `clear` in 1: synchronous flush, same signal the controller uses.
- `ext_stall` in 1: external port-busy signal (shared RAM arbitration). Forces both ready signals low.
- `stk_ram_if` `StkRamIf.Slave`, which carries:
  - `wr_vld` in 1
  - `wr_adr` in AW
  - `wr_dat` in DW
  - `wr_rdy` out 1
  - `rd_vld` in 1
  - `rd_adr` in AW
  - `rd_rdy` out 1
  - `rd_ack` out 1
  - `rd_dat` out DW
- `init_done` out 1: high once the zero sweep is complete.
- `err_oor` out 1: sticky out-of-range flag.

## Operation
- **FSM states.** `INIT` and `RUN`.
  - Reset, or `rst_n` asserted at any time including mid-operation, enters `INIT`. The init counter restarts at 0.
  - In `INIT`, one word per cycle (`mem[cnt] <= 0`) for `cnt = 0 .. RAM_DEPTH-1`. After the cycle that writes `RAM_DEPTH-1`, the FSM moves to `RUN`.
  - `RUN` is left only by reset. `clear` does not re-run `INIT`.
- **Ready signals** (combinational):
  - `wr_rdy = RUN && !ext_stall && !clear`.
  - `rd_rdy = RUN && !ext_stall && !clear && !wr_vld`. Writes win when both valids are high; the read waits.
- **Write.** A write is accepted when `wr_vld && wr_rdy`.
  - If `wr_adr < RAM_DEPTH`, then `mem[wr_adr] <= wr_dat`.
  - Otherwise the write is dropped and `err_oor` is set.
- **Read.** A read is accepted when `rd_vld && rd_rdy`. Each accepted read enters an `RD_LAT`-deep valid/data pipeline.
  - Reads are fully pipelined: one accept per cycle sustained.
  - An out-of-range read returns all zeros, still acks, and sets `err_oor`.
- **Read-after-write.** A write accepted in cycle t is visible to a read accepted in cycle t+1 or later.
- **`clear`.**
  - Squashes every in-flight read: no `rd_ack` is issued for reads accepted before or during the clear cycle.
  - Clears `err_oor`.
  - Memory contents are unchanged.
- **`err_oor` priority.** Set and clear in the same cycle resolves to clear.

## Timing
- **Reset values:**
  - `wr_rdy = 0`
  - `rd_rdy = 0`
  - `rd_ack = 0`
  - `rd_dat = 0`
  - `init_done = 0`
  - `err_oor = 0`
  - FSM in `INIT`, init counter at 0.
- **Init duration.** Exactly `RAM_DEPTH` cycles after reset release. `init_done` and both ready signals go high in cycle `RAM_DEPTH` (0-based, counting the first cycle after release as 0).
- **Read latency.**
  - A read accepted in cycle t gives `rd_ack = 1` for exactly one cycle, in cycle t+`RD_LAT`.
  - `rd_dat` is valid in that cycle and holds its value until the next ack.
  - `rd_ack` is never asserted without a matching accept.
- **Write timing.** A write accepted in cycle t updates the array at the edge ending cycle t.
- **`ext_stall`.** Ready drops in the same cycle `ext_stall` is high. Requests held by the controller are accepted in the first cycle `ext_stall` is low. Reads already in flight still ack on schedule.
- **`err_oor` timing.** Sets at the edge ending the offending accept cycle.
- **Burst reference.** A 4-beat burst with no stall takes 4 consecutive accept cycles. The last read ack arrives at t0+3+`RD_LAT`.

## Test plan
- **Reset and init, `RAM_DEPTH=24`.** Release reset, then count cycles → `wr_rdy`, `rd_rdy` and `init_done` rise exactly 24 cycles later. A read of address 23 at `RD_LAT=1` returns 0 one cycle after accept.
- **Spill/fill burst.** Write addresses 4..7 with data 0xA0..0xA3 on back-to-back cycles, then read 4..7 back-to-back → 4 consecutive `rd_ack` pulses carrying 0xA0..0xA3, the first one `RD_LAT` cycles after the first read accept. Run with `RD_LAT=1` and `RD_LAT=2`.
- **Simultaneous valids.** `wr_vld` (address 2, 0x55) and `rd_vld` (address 2) high together → cycle 1: `rd_rdy = 0`, write accepted. Cycle 2: read accepted. Ack returns 0x55.
- **Backpressure.** Hold `ext_stall` high for 3 cycles during a 4-beat write burst → no accepts while stalled; the burst completes 3 cycles late; the array matches the unstalled result.
- **Out-of-range.** Write address 24, then read address 30 → write dropped and `err_oor = 1` the next cycle. The read acks with data 0. A `clear` pulse returns `err_oor` to 0.
- **Clear and reset mid-operation.**
  - Clear: accept a read with `RD_LAT=2`, pulse `clear` one cycle later → no `rd_ack`.
  - Reset: assert `rst_n=0` at init count 10 → all outputs return to reset values immediately, and a full 24-cycle init restarts on release.
